// File: rtl/sort_pkg.sv
// sort_pkg: frame geometry, element types and capture states shared with the sorter
package sort_pkg;
  localparam int SIZE = 15;
  localparam int DATA_W = 8;
  localparam int ROW_W = 4;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ROW_W-1:0] row_t;
  typedef enum logic {SYNC, CAPTURE} state_t;
endpackage

// File: rtl/sort_frame_buf.sv
// sort_frame_buf: shadow frame store with whole-frame commit and zero-padded read port
module sort_frame_buf import sort_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              commit,
  input  logic [ROW_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ROW_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  data_t shadow [SIZE];
  data_t committed [SIZE];
  // the beat completing the frame is forwarded straight into the committed copy
  always_ff @(posedge clk)
    for (int i = 0; i < SIZE; i++)
      if (rst) begin
        shadow[i] <= '0;
        committed[i] <= '0;
      end else begin
        if (wr_en && wr_addr == ROW_W'(i)) shadow[i] <= wr_data;
        if (commit) committed[i] <= (wr_en && wr_addr == ROW_W'(i)) ? wr_data : shadow[i];
      end
  assign rd_data = (rd_addr < ROW_W'(SIZE)) ? committed[rd_addr] : '0;
endmodule

// File: rtl/sort_stream_capture.sv
// sort_stream_capture: frame-locked capture and self-check of the row stream (checksum enabled by STREAM_CHECKSUM_EN)
module sort_stream_capture import sort_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ROW_W-1:0]  in_row,
  input  logic [ROW_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_done,
  output logic              frame_sorted,
  output logic [DATA_W-1:0] min_val,
  output logic [DATA_W-1:0] max_val,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              seq_err,
  output logic [DATA_W-1:0] checksum
);
  state_t state;
  row_t exp_row;
  logic [DATA_W-1:0] run_min, run_max, prev, nxt_min, nxt_max;
  logic order_bad, nxt_bad, seed, hit, bad, last;
  // a row-0 beat always (re)starts a frame, whether expected, a resync or a restart after error
  always_comb begin
    seed = in_valid && in_row == '0;
    hit = in_valid && state == CAPTURE && in_row == exp_row && in_row != '0;
    bad = in_valid && state == CAPTURE && in_row != exp_row;
    last = hit && in_row == ROW_W'(SIZE - 1);
    nxt_min = (in_data < run_min) ? in_data : run_min;
    nxt_max = (in_data > run_max) ? in_data : run_max;
    nxt_bad = order_bad || (in_data < prev);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= SYNC;
      exp_row <= '0;
      run_min <= '0;
      run_max <= '0;
      prev <= '0;
      order_bad <= 1'b0;
      frame_done <= 1'b0;
      frame_sorted <= 1'b0;
      min_val <= '0;
      max_val <= '0;
      frame_cnt <= '0;
      seq_err <= 1'b0;
    end else begin
      frame_done <= last;
      seq_err <= bad;
      if (seed) begin
        state <= CAPTURE;
        exp_row <= ROW_W'(1);
        run_min <= in_data;
        run_max <= in_data;
        prev <= in_data;
        order_bad <= 1'b0;
      end else if (hit) begin
        exp_row <= last ? '0 : exp_row + 1'b1;
        run_min <= nxt_min;
        run_max <= nxt_max;
        prev <= in_data;
        order_bad <= nxt_bad;
      end else if (bad) begin
        state <= SYNC;
        exp_row <= '0;
      end
      if (last) begin
        frame_sorted <= !nxt_bad;
        min_val <= nxt_min;
        max_val <= nxt_max;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
`ifdef STREAM_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  always_ff @(posedge clk)
    if (rst) begin
      sum <= '0;
      checksum <= '0;
    end else begin
      sum <= seed ? in_data : hit ? sum + in_data : bad ? '0 : sum;
      if (last) checksum <= sum + in_data;
    end
`else
  assign checksum = '0;
`endif
  sort_frame_buf u_buf (
    .clk(clk),
    .rst(rst),
    .wr_en(seed || hit),
    .commit(last),
    .wr_addr(in_row),
    .wr_data(in_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
endmodule

// File: tb/tb_sort_stream_capture.sv
// tb_sort_stream_capture: randomized scoreboard bench for sort_stream_capture
module tb_sort_stream_capture;
  import sort_pkg::*;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [3:0] in_row = '0, rd_addr = '0;
  logic [7:0] rd_data, min_val, max_val, checksum;
  logic frame_done, frame_sorted, seq_err;
  logic [15:0] frame_cnt;
  int ncmp = 0, nfail = 0, cyc = 0, rst_req = 0, rst_seen = 0, mcnt = 0;
  bit in_frame = 0;
  logic [7:0] cur[$];
  logic [7:0] fd [SIZE];
  typedef struct packed {
    logic err;
    logic sorted;
    logic [7:0] mn, mx, sum;
    logic [15:0] cnt;
    int at;
    logic [SIZE-1:0][7:0] d;
  } ev_t;
  ev_t sb[$];

  sort_stream_capture dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_row(in_row),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_done(frame_done), .frame_sorted(frame_sorted),
    .min_val(min_val), .max_val(max_val), .frame_cnt(frame_cnt), .seq_err(seq_err),
    .checksum(checksum)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference: a frame is the list of beats whose rows count 0,1,2,... without a break
  task automatic model(input logic [3:0] r, input logic [7:0] v);
    ev_t e;
    e = '0;
    e.at = cyc;
    if (!in_frame) begin
      if (r == 0) begin
        cur.delete();
        cur.push_back(v);
        in_frame = 1;
      end
    end else if (int'(r) == cur.size()) begin
      cur.push_back(v);
      if (cur.size() == SIZE) begin
        mcnt++;
        e.cnt = 16'(mcnt);
        e.sorted = 1;
        e.mn = 8'hff;
        for (int i = 0; i < SIZE; i++) begin
          e.d[i] = cur[i];
          if (i > 0 && cur[i] < cur[i-1]) e.sorted = 0;
          if (cur[i] < e.mn) e.mn = cur[i];
          if (cur[i] > e.mx) e.mx = cur[i];
          e.sum = e.sum + cur[i];
        end
        cur.delete();
        sb.push_back(e);
      end
    end else begin
      e.err = 1;
      sb.push_back(e);
      cur.delete();
      if (r == 0) cur.push_back(v);
      else in_frame = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 0;
      in_row = 4'($urandom);
      in_data = 8'($urandom);
    end
  endtask

  task automatic beat(input logic [3:0] r, input logic [7:0] v);
    @(negedge clk);
    in_valid = 1;
    in_row = r;
    in_data = v;
    @(posedge clk);
    model(r, v);
  endtask

  task automatic rows(input int lo, input int hi, input int gap);
    for (int i = lo; i <= hi; i++) begin
      beat(4'(i), fd[i]);
      if (gap > 0 && i < hi) idle(gap);
    end
  endtask

  task automatic ramp();
    for (int i = 0; i < SIZE; i++) fd[i] = 8'(5 * (i + 1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    in_valid = 0;
    @(negedge clk);
    rst = 0;
    cur.delete();
    in_frame = 0;
    mcnt = 0;
    rst_req++;
    idle(3);
  endtask

  always @(negedge clk) begin
    if (rst_req != rst_seen) begin
      rst_seen = rst_req;
      chk("rst_outputs", {frame_done, frame_sorted, seq_err, min_val, max_val, checksum}, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      for (int a = 0; a < 16; a++) begin
        rd_addr = 4'(a);
        #1;
        chk("rst_rd_data", rd_data, 0);
      end
    end
    if (frame_done || seq_err) begin
      if (sb.size() == 0) chk("spurious_event", {frame_done, seq_err}, 0);
      else begin
        ev_t e;
        e = sb.pop_front();
        chk("seq_err", seq_err, e.err);
        chk("frame_done", frame_done, !e.err);
        chk("event_cycle", cyc, e.at + 1);
        if (!e.err) begin
          chk("frame_sorted", frame_sorted, e.sorted);
          chk("min_val", min_val, e.mn);
          chk("max_val", max_val, e.mx);
          chk("frame_cnt", frame_cnt, e.cnt);
`ifdef STREAM_CHECKSUM_EN
          chk("checksum", checksum, e.sum);
`else
          chk("checksum", checksum, 0);
`endif
          for (int a = 0; a < 16; a++) begin
            logic [7:0] x;
            x = (a < SIZE) ? e.d[a] : 8'h0;
            rd_addr = 4'(a);
            #1;
            chk("rd_data", rd_data, x);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    do_reset();
    ramp();
    rows(0, 14, 0);
    idle(2);
    fd[6] = 3;
    rows(0, 14, 0);
    idle(2);
    ramp();
    rows(9, 14, 0);
    rows(0, 14, 0);
    idle(1);
    rows(0, 2, 0);
    rows(4, 4, 0);
    idle(2);
    rows(0, 14, 0);
    rows(0, 4, 0);
    rows(0, 14, 0);
    idle(2);
    rows(0, 14, 3);
    rows(0, 14, 0);
    rows(0, 14, 0);
    idle(2);
    for (int n = 0; n < 25; n++) begin
      int g, p;
      logic [3:0] br;
      g = $urandom_range(0, 2);
      fd[0] = 8'($urandom_range(0, 30));
      for (int i = 1; i < SIZE; i++)
        fd[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'(fd[i-1] + $urandom_range(0, 14));
      if ($urandom_range(0, 3) == 0) begin
        p = $urandom_range(1, SIZE - 1);
        br = 4'($urandom_range(0, 15));
        if (br == 4'(p)) br = br + 1'b1;
        rows(0, p - 1, g);
        beat(br, 8'($urandom));
        rows(p, 14, g);
      end else rows(0, 14, g);
      idle($urandom_range(0, 2));
    end
    ramp();
    rows(0, 14, 0);
    rows(0, 8, 0);
    do_reset();
    for (int i = 0; i < SIZE; i++) fd[i] = 8'd20;
    rows(0, 14, 0);
    idle(5);
    chk("queue_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/sort_stream_capture.md
Name: sort_stream_capture

Overview:
Receiving end of the sorter's row-scan output stream (data byte plus row index, rows 0..SIZE-1 repeating). Locks onto row 0 and captures each full frame into a shadow buffer. At frame end it commits the frame to a readable buffer and reports sortedness, min/max and a frame count. Sits downstream of the sorter/row-mux pair as the on-chip consumer and self-checker of sorted results.

Parameters:
SIZE, 15, entries per frame (rows 0..SIZE-1)
DATA_W, 8, data byte width
ROW_W, 4, row index width; must satisfy 2**ROW_W >= SIZE
CNT_W, 16, frame counter width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  beat qualifier; held high by a continuous source
in_data  in  DATA_W  streamed element
in_row  in  ROW_W  row index of in_data
rd_addr  in  ROW_W  committed-buffer read address
rd_data  out  DATA_W  committed[rd_addr], combinational; 0 when rd_addr >= SIZE
frame_done  out  1  one-cycle pulse, frame committed
frame_sorted  out  1  last committed frame non-decreasing
min_val  out  DATA_W  minimum of last committed frame
max_val  out  DATA_W  maximum of last committed frame
frame_cnt  out  CNT_W  committed frames, wraps at 2**CNT_W
seq_err  out  1  one-cycle pulse, row-sequence violation
checksum  out  DATA_W  see Optional Feature

Behaviour:
- Reset (synchronous, active-high): state SYNC, exp_row 0, shadow and committed buffers 0; all outputs 0.
- A beat is accepted only when in_valid=1. With in_valid=0, nothing changes; there is no timeout.
- SYNC state:
  - Discard beats until an accepted beat with in_row==0.
  - That beat is written to shadow[0], seeds the running min/max/prev, clears order_bad, sets exp_row 1 and moves to CAPTURE.
- CAPTURE state, accepted beat with in_row==exp_row:
  - shadow[in_row] <= in_data.
  - order_bad |= (in_data < prev).
  - Update running min/max; prev <= in_data.
  - exp_row increments.
- CAPTURE state, accepted beat with in_row==SIZE-1 (and correct): commit.
  - Next cycle: committed buffer <= shadow including this beat.
  - frame_sorted <= !order_bad; min_val/max_val updated; frame_cnt +1 (wraps).
  - frame_done pulses high for exactly that one cycle.
  - exp_row returns to 0; state stays CAPTURE, so back-to-back frames are gap-free.
- CAPTURE state, accepted beat with in_row != exp_row, or in_row >= SIZE:
  - seq_err pulses the following cycle; the partial frame is discarded with no commit.
  - If that beat has in_row==0, it restarts capture exactly as in SYNC (same cycle). Otherwise the block returns to SYNC.
- The committed buffer and stats change only on commit. rd_data reflects the new frame in the same cycle frame_done is high.
- Equal adjacent values count as sorted. Comparisons are unsigned.
- Reset mid-frame: partial frame dropped, committed buffer and stats cleared, frame_cnt 0.

Optional Feature:
Macro STREAM_CHECKSUM_EN.
- Defined: running 8-bit modular sum of accepted in_data over the frame. Committed to checksum alongside the other stats at frame_done; cleared by reset and on seq_err restart.
- Undefined: no accumulator is built and checksum is tied to 0.

Decomposition:
- Package sort_pkg holds:
  - SIZE, DATA_W, ROW_W constants shared with the sorter.
  - State enum {SYNC, CAPTURE}.
  - Row and data typedefs.
- One sub-module, sort_frame_buf: shadow array, committed array, commit strobe, combinational read port with out-of-range zeroing.
- Sequencing, order check, min/max and counter remain in sort_stream_capture.

Test Plan:
1. Rows 0..14, data 5,10,...,75, in_valid=1 -> frame_done one cycle after row 14; frame_sorted=1, min 5, max 75, frame_cnt 1; rd_addr 7 gives rd_data 40; rd_addr 15 gives 0.
2. As test 1 but row 6 data=3 -> frame_sorted=0, min 3, max 75, frame_cnt 1.
3. Start mid-stream with rows 9..14, then a full 0..14 frame -> no frame_done or seq_err during rows 9..14; exactly one frame_done after the full frame; frame_cnt 1.
4. Rows 0,1,2,4 -> seq_err one cycle after the row-4 beat, no frame_done; a following full frame commits normally. A row-0 beat arriving at exp_row 5 gives seq_err and immediately restarts capture.
5. Test 1 stream with in_valid low for 3 cycles between every beat -> identical results; then two back-to-back frames -> two frame_done pulses 15 cycles apart, frame_cnt 2.
6. Assert rst after row 8 of a second frame -> all outputs 0 and rd_data 0 everywhere. With STREAM_CHECKSUM_EN, a frame of all-20 data -> frame_sorted=1, checksum 44 (300 mod 256); without the macro, checksum stays 0.
